// File: rtl/truth_table_sweep_pkg.sv
// Shared types and constants for the truth_table sweep controller.
// Holds the state encoding, field widths and default expected result maps.
package truth_table_sweep_pkg;

    localparam int unsigned CODE_W = 3;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned MAP_W  = 8;
    localparam int unsigned ERR_W  = 4;

    localparam logic [CODE_W-1:0] LAST_CODE = CODE_W'(7);

    localparam logic [MAP_W-1:0] X_EXP_DEF = 8'h4D;
    localparam logic [MAP_W-1:0] Y_EXP_DEF = 8'h96;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/truth_table_sweep_if.sv
// Signal bundle between the sweep controller and its environment
// (start request, truth_table drive/return, status and result maps).
interface truth_table_sweep_if;
    import truth_table_sweep_pkg::*;

    logic               start;
    logic               Ain;
    logic               Bin;
    logic               Cin;
    logic               x_in;
    logic               y_in;
    logic               busy;
    logic               done;
    logic [MAP_W-1:0]   x_map;
    logic [MAP_W-1:0]   y_map;
    logic [ERR_W-1:0]   err_count;
    logic               pass;

    modport master (
        input  start, x_in, y_in,
        output Ain, Bin, Cin, busy, done, x_map, y_map, err_count, pass
    );

    modport slave (
        output start, x_in, y_in,
        input  Ain, Bin, Cin, busy, done, x_map, y_map, err_count, pass
    );
endinterface

// File: rtl/truth_table_sweep.sv
// Sweeps a combinational truth_table through all eight input codes, captures
// X/Y per code and compares them against expected maps.
module truth_table_sweep
    import truth_table_sweep_pkg::*;
#(
    parameter int unsigned      SETTLE = 2,
    parameter logic [MAP_W-1:0] X_EXP  = X_EXP_DEF,
    parameter logic [MAP_W-1:0] Y_EXP  = Y_EXP_DEF
) (
    input  logic                clk,
    input  logic                rst,
    truth_table_sweep_if.master bus
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

    state_e              state_q, state_d;
    logic [CODE_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [MAP_W-1:0]    x_map_q, x_map_d;
    logic [MAP_W-1:0]    y_map_q, y_map_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic                mismatch_c;

    // X/Z on the returned values must count as a mismatch in simulation
    assign mismatch_c = (bus.x_in !== X_EXP[idx_q]) || (bus.y_in !== Y_EXP[idx_q]);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        x_map_d = x_map_q;
        y_map_d = y_map_q;
        err_d   = err_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = DRIVE;
                    idx_d   = '0;
                    cnt_d   = CNT_LOAD;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    x_map_d = '0;
                    y_map_d = '0;
                    err_d   = '0;
                end
            end
            DRIVE: begin
                if (cnt_q == '0) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            SAMPLE: begin
                x_map_d[idx_q] = bus.x_in;
                y_map_d[idx_q] = bus.y_in;
                err_d          = err_q + ERR_W'(mismatch_c);
                if (idx_q != LAST_CODE) begin
                    state_d = DRIVE;
                    idx_d   = idx_q + CODE_W'(1);
                    cnt_d   = CNT_LOAD;
                end else begin
                    // pass uses the count including this final code
                    state_d = DONE;
                    idx_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            x_map_q <= '0;
            y_map_q <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            x_map_q <= x_map_d;
            y_map_q <= y_map_d;
            err_q   <= err_d;
        end
    end

    assign bus.Ain       = idx_q[2];
    assign bus.Bin       = idx_q[1];
    assign bus.Cin       = idx_q[0];
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.x_map     = x_map_q;
    assign bus.y_map     = y_map_q;
    assign bus.err_count = err_q;

endmodule

// File: tb/tb_truth_table_sweep.sv
// Bench for truth_table_sweep: a table-driven truth_table stand-in feeds X/Y,
// and each sweep is compared against maps and error counts derived from the tables.
module tb_truth_table_sweep;

    localparam int unsigned SETTLE = 2;
    localparam int unsigned HOLD   = SETTLE + 1;
    localparam int unsigned NCODE  = 8;
    localparam logic [7:0]  XG     = 8'h4D;
    localparam logic [7:0]  YG     = 8'h96;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] xtab;
    logic [7:0] ytab;
    int         n_checks = 0;
    int         n_fail   = 0;

    truth_table_sweep_if bus();

    truth_table_sweep #(.SETTLE(SETTLE), .X_EXP(XG), .Y_EXP(YG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    // Stand-in truth_table: whatever table the current test loads
    assign bus.x_in = xtab[{bus.Ain, bus.Bin, bus.Cin}];
    assign bus.y_in = ytab[{bus.Ain, bus.Bin, bus.Cin}];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Number of codes where either output differs from its expected map
    function automatic int model_err(input logic [7:0] xt, input logic [7:0] yt);
        int n = 0;
        for (int i = 0; i < int'(NCODE); i++)
            if (xt[i] != XG[i] || yt[i] != YG[i]) n++;
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
        check({tag, "_pass"}, 32'(bus.pass), 32'd0);
        check({tag, "_xmap"}, 32'(bus.x_map), 32'd0);
        check({tag, "_ymap"}, 32'(bus.y_map), 32'd0);
        check({tag, "_err"},  32'(bus.err_count), 32'd0);
        check({tag, "_abc"},  32'({bus.Ain, bus.Bin, bus.Cin}), 32'd0);
    endtask

    // One complete sweep; restart_at >= 0 pulses start that many cycles after E
    task automatic run_sweep(input string tag, input logic [7:0] xt, input logic [7:0] yt,
                             input int restart_at);
        int exp_err;
        xtab    = xt;
        ytab    = yt;
        exp_err = model_err(xt, yt);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check({tag, "_clr_done"}, 32'(bus.done), 32'd0);
        check({tag, "_clr_pass"}, 32'(bus.pass), 32'd0);
        check({tag, "_clr_err"},  32'(bus.err_count), 32'd0);
        check({tag, "_clr_map"},  32'({bus.x_map, bus.y_map}), 32'd0);
        for (int k = 0; k < int'(HOLD * NCODE); k++) begin
            if (k > 0) begin
                tick();
                bus.start = 1'b0;
            end
            check({tag, "_busy"}, 32'(bus.busy), 32'd1);
            check({tag, "_nodone"}, 32'(bus.done), 32'd0);
            check({tag, "_code"}, 32'({bus.Ain, bus.Bin, bus.Cin}), 32'(k / int'(HOLD)));
            if (k == restart_at) bus.start = 1'b1;
        end
        tick();
        bus.start = 1'b0;
        for (int h = 0; h < 3; h++) begin
            check({tag, "_done"}, 32'(bus.done), 32'd1);
            check({tag, "_idle"}, 32'(bus.busy), 32'd0);
            check({tag, "_abc0"}, 32'({bus.Ain, bus.Bin, bus.Cin}), 32'd0);
            check({tag, "_xmap"}, 32'(bus.x_map), 32'(xt));
            check({tag, "_ymap"}, 32'(bus.y_map), 32'(yt));
            check({tag, "_err"},  32'(bus.err_count), 32'(exp_err));
            check({tag, "_pass"}, 32'(bus.pass), 32'(exp_err == 0));
            tick();
        end
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        xtab      = XG;
        ytab      = YG;
        tick();
        tick();
        check_reset_vals("reset");
        rst = 1'b0;
        tick();
        check_reset_vals("idle");

        run_sweep("golden", XG, YG, -1);
        run_sweep("stuck0", 8'h00, 8'h00, -1);
        run_sweep("invy", XG, ~YG, -1);
        run_sweep("restart", XG, YG, 5);

        // Reset mid-sweep, then a clean golden sweep
        xtab = XG;
        ytab = YG;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 1; k < 10; k++) tick();
        check("mid_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        tick();
        check_reset_vals("midrst");
        rst = 1'b0;
        tick();
        run_sweep("postrst", XG, YG, -1);

        // Random tables and single-bit faults
        for (int r = 0; r < 6; r++) begin
            logic [7:0] xr, yr;
            xr = 8'($urandom);
            yr = 8'($urandom);
            run_sweep("rand", xr, yr, -1);
        end
        for (int r = 0; r < 4; r++) begin
            logic [7:0] fx, fy;
            fx = XG;
            fy = YG;
            if (r[0]) fx[$urandom_range(7, 0)] ^= 1'b1;
            else      fy[$urandom_range(7, 0)] ^= 1'b1;
            run_sweep("onebit", fx, fy, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
